rv_iopmp_check_requester: RTL and testbench
===========================================

Name: rv_iopmp_check_requester

Overview:
- Initiator side of the IOPMP transaction-check handshake.
- Accepts read and write burst requests from the bus-facing front end and arbitrates between them round-robin.
- Converts each burst into a matcher transaction (start address, total length, beat bytes, SID, access type) and holds it stable until the matcher completes.
- Returns one allow/deny verdict per burst on a valid/ready response channel, with local illegal-size rejection and a watchdog timeout.

Parameters:
ADDR_WIDTH, 64, address and total-length width
DATA_WIDTH, 64, bus data width; max beat bytes = DATA_WIDTH/8
SID_WIDTH, 8, source-ID width
LEN_WIDTH, 8, burst length field width (encoded beats-1)
TIMEOUT_CYCLES, 64, max WAIT cycles before forced deny; 0 disables the timeout

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
rd_req_valid_i  in  1  read burst request valid
rd_req_ready_o  out  1  read request accepted this cycle
rd_req_addr_i  in  ADDR_WIDTH  read start address
rd_req_len_i  in  LEN_WIDTH  read beats-1
rd_req_size_i  in  3  read log2(bytes per beat)
rd_req_sid_i  in  SID_WIDTH  read source ID
wr_req_valid_i / wr_req_ready_o / wr_req_addr_i / wr_req_len_i / wr_req_size_i / wr_req_sid_i  as read channel, write side
rsp_valid_o  out  1  verdict valid
rsp_ready_i  in  1  verdict consumed
rsp_allow_o  out  1  1 = permitted
rsp_is_write_o  out  1  verdict belongs to a write request
rsp_timeout_o  out  1  deny caused by the watchdog
rsp_illegal_o  out  1  deny caused by illegal size
transaction_en_o  out  1  matcher request strobe
addr_o  out  ADDR_WIDTH  start address to matcher
total_length_o  out  ADDR_WIDTH  (len+1) << size
num_bytes_o  out  $clog2(DATA_WIDTH/8)+1  1 << size
sid_o  out  SID_WIDTH  source ID
access_type_o  out  rv_iopmp_pkg::access_t  ACCESS_READ or ACCESS_WRITE
matcher_ready_i  in  1  matcher idle
matcher_valid_i  in  1  matcher verdict strobe
matcher_allow_i  in  1  matcher verdict

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_i is synchronous, active-high.
- Reset values: FSM in IDLE. All outputs 0. access_type_o = ACCESS_NONE. Round-robin pointer = read-preferred. pending_late = 0. Timeout counter = 0.
- Request registers hold addr, len, size, SID, and the is_write flag. They are written only on a request accept. addr_o, total_length_o, num_bytes_o, sid_o and access_type_o are driven from these registers, so they stay stable from ISSUE to IDLE.
- Arithmetic: total_length = (len+1) << size, zero-extended to ADDR_WIDTH, no saturation.
- Illegal size: size > log2(DATA_WIDTH/8).
- IDLE:
  - Accepts only when !rsp_valid_o and !pending_late.
  - If exactly one channel is valid, grant it. If both are valid, grant the channel not granted last.
  - The grant asserts the matching *_req_ready_o combinationally for that cycle only. The grant updates the pointer and loads the request registers.
  - Next state: RESP with allow=0, illegal=1 if size is illegal; otherwise ISSUE.
- ISSUE:
  - transaction_en_o = matcher_ready_i.
  - When matcher_ready_i=1, go to WAIT and clear the counter. The strobe is high for exactly one cycle.
  - Otherwise stay in ISSUE, with no timeout.
- WAIT:
  - If matcher_valid_i=1, latch matcher_allow_i and go to RESP. A same-cycle valid wins over the timeout.
  - Otherwise the counter increments each cycle. When TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1, go to RESP with allow=0, timeout=1, and set pending_late.
- RESP:
  - rsp_valid_o=1 and the rsp_* fields are held until rsp_ready_i. Then go to IDLE.
  - No new request is accepted in the handshake cycle.
- pending_late: cleared by matcher_valid_i in any state. The late verdict is discarded and never reaches rsp_*.
- Throughput: one burst in flight. Minimum latency from request accept to rsp_valid_o is 3 cycles when the matcher replies in its first WAIT cycle.
- Reset mid-operation: all state returns to reset values. The in-flight burst produces no response.

Test Plan:
- Read, addr=0x1000, len=3, size=3, sid=1; matcher_ready=1; valid+allow two cycles after the strobe → one-cycle transaction_en_o, total_length_o=32, num_bytes_o=8, ACCESS_READ; rsp_allow_o=1, rsp_is_write_o=0.
- Read and write valid together in three consecutive accepts → grant order read, write, read; each rd/wr_req_ready_o pulses for exactly one cycle.
- Write with size=4 (DATA_WIDTH=64) → no transaction_en_o; rsp_valid_o with allow=0, illegal=1.
- TIMEOUT_CYCLES=4, matcher never valid → deny with timeout=1. A read presented meanwhile is not accepted until matcher_valid_i arrives; that late allow=1 is discarded.
- matcher_ready_i=0 for 10 cycles in ISSUE → no timeout; transaction_en_o pulses once when ready rises, and the outputs stay stable throughout.
- rsp_ready_i held low for 5 cycles → rsp_* stay stable and both req_ready outputs stay 0. Assert rst_i in WAIT → next cycle all outputs 0, no response is emitted.

Source files
------------

// File: rtl/rv_iopmp_check_requester.sv
// IOPMP transaction-check requester: arbitrates read/write bursts round-robin,
// issues one matcher transaction per burst and returns a single allow/deny verdict.
package rv_iopmp_pkg;
    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2
    } access_t;
endpackage

module rv_iopmp_check_requester #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int SID_WIDTH      = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  rd_req_valid_i,
    output logic                                  rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]                 rd_req_addr_i,
    input  logic [LEN_WIDTH-1:0]                  rd_req_len_i,
    input  logic [2:0]                            rd_req_size_i,
    input  logic [SID_WIDTH-1:0]                  rd_req_sid_i,
    input  logic                                  wr_req_valid_i,
    output logic                                  wr_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]                 wr_req_addr_i,
    input  logic [LEN_WIDTH-1:0]                  wr_req_len_i,
    input  logic [2:0]                            wr_req_size_i,
    input  logic [SID_WIDTH-1:0]                  wr_req_sid_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic                                  rsp_allow_o,
    output logic                                  rsp_is_write_o,
    output logic                                  rsp_timeout_o,
    output logic                                  rsp_illegal_o,
    output logic                                  transaction_en_o,
    output logic [ADDR_WIDTH-1:0]                 addr_o,
    output logic [ADDR_WIDTH-1:0]                 total_length_o,
    output logic [$clog2(DATA_WIDTH/8):0]         num_bytes_o,
    output logic [SID_WIDTH-1:0]                  sid_o,
    output rv_iopmp_pkg::access_t                 access_type_o,
    input  logic                                  matcher_ready_i,
    input  logic                                  matcher_valid_i,
    input  logic                                  matcher_allow_i
);
    import rv_iopmp_pkg::*;

    localparam int MAX_SIZE = $clog2(DATA_WIDTH/8);
    localparam int NB_W     = MAX_SIZE + 1;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic                   prefer_wr;
    logic                   pending_late;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_WIDTH-1:0]  addr_q, tlen_q;
    logic [NB_W-1:0]        nbytes_q;
    logic [SID_WIDTH-1:0]   sid_q;
    access_t                access_q;
    logic                   allow_q, is_write_q, timeout_q, illegal_q;

    logic                   can_accept, grant_rd, grant_wr, grant;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic [2:0]             sel_size;
    logic [SID_WIDTH-1:0]   sel_sid;
    logic                   sel_illegal;
    logic                   timeout_hit;

    assign rsp_valid_o = (state_q == S_RESP);
    // A pending late verdict from a timed-out burst must drain before the matcher is reused.
    assign can_accept  = (state_q == S_IDLE) && !rsp_valid_o && !pending_late;
    assign grant_rd    = can_accept && rd_req_valid_i && (!wr_req_valid_i || !prefer_wr);
    assign grant_wr    = can_accept && wr_req_valid_i && (!rd_req_valid_i || prefer_wr);
    assign grant       = grant_rd || grant_wr;

    assign sel_addr    = grant_wr ? wr_req_addr_i : rd_req_addr_i;
    assign sel_len     = grant_wr ? wr_req_len_i  : rd_req_len_i;
    assign sel_size    = grant_wr ? wr_req_size_i : rd_req_size_i;
    assign sel_sid     = grant_wr ? wr_req_sid_i  : rd_req_sid_i;
    assign sel_illegal = (sel_size > 3'(MAX_SIZE));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    assign rd_req_ready_o   = grant_rd;
    assign wr_req_ready_o   = grant_wr;
    assign transaction_en_o = (state_q == S_ISSUE) && matcher_ready_i;
    assign addr_o           = addr_q;
    assign total_length_o   = tlen_q;
    assign num_bytes_o      = nbytes_q;
    assign sid_o            = sid_q;
    assign access_type_o    = access_q;
    assign rsp_allow_o      = allow_q;
    assign rsp_is_write_o   = is_write_q;
    assign rsp_timeout_o    = timeout_q;
    assign rsp_illegal_o    = illegal_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = sel_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: if (matcher_ready_i) state_d = S_WAIT;
            S_WAIT:  if (matcher_valid_i || timeout_hit) state_d = S_RESP;
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            prefer_wr    <= 1'b0;
            pending_late <= 1'b0;
            cnt          <= '0;
            addr_q       <= '0;
            tlen_q       <= '0;
            nbytes_q     <= '0;
            sid_q        <= '0;
            access_q     <= ACCESS_NONE;
            allow_q      <= 1'b0;
            is_write_q   <= 1'b0;
            timeout_q    <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (matcher_valid_i) pending_late <= 1'b0;
            if (grant) begin
                prefer_wr  <= grant_rd;
                addr_q     <= sel_addr;
                tlen_q     <= (ADDR_WIDTH'(sel_len) + ADDR_WIDTH'(1)) << sel_size;
                nbytes_q   <= NB_W'(1) << sel_size;
                sid_q      <= sel_sid;
                access_q   <= grant_wr ? ACCESS_WRITE : ACCESS_READ;
                is_write_q <= grant_wr;
                allow_q    <= 1'b0;
                timeout_q  <= 1'b0;
                illegal_q  <= sel_illegal;
            end
            case (state_q)
                S_ISSUE: if (matcher_ready_i) cnt <= '0;
                S_WAIT: begin
                    if (matcher_valid_i) begin
                        allow_q <= matcher_allow_i;
                    end else if (timeout_hit) begin
                        allow_q      <= 1'b0;
                        timeout_q    <= 1'b1;
                        pending_late <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: if (rsp_ready_i) begin
                    allow_q    <= 1'b0;
                    is_write_q <= 1'b0;
                    timeout_q  <= 1'b0;
                    illegal_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_iopmp_check_requester.sv
// Directed bench for rv_iopmp_check_requester: arbitration, illegal size,
// watchdog with late-verdict drain, matcher back-pressure, response stall, reset.
module tb_rv_iopmp_check_requester;
    import rv_iopmp_pkg::*;

    localparam int AW = 64;
    localparam int SW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid, rd_ready, wr_valid, wr_ready;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [LW-1:0] rd_len, wr_len;
    logic [2:0]    rd_size, wr_size;
    logic [SW-1:0] rd_sid, wr_sid;
    logic          rsp_valid, rsp_ready, rsp_allow, rsp_is_write, rsp_timeout, rsp_illegal;
    logic          txn_en;
    logic [AW-1:0] addr, tlen;
    logic [3:0]    nbytes;
    logic [SW-1:0] sid;
    access_t       acc;
    logic          m_ready, m_valid, m_allow;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv_iopmp_check_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(64), .SID_WIDTH(SW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_req_valid_i(rd_valid), .rd_req_ready_o(rd_ready), .rd_req_addr_i(rd_addr),
        .rd_req_len_i(rd_len), .rd_req_size_i(rd_size), .rd_req_sid_i(rd_sid),
        .wr_req_valid_i(wr_valid), .wr_req_ready_o(wr_ready), .wr_req_addr_i(wr_addr),
        .wr_req_len_i(wr_len), .wr_req_size_i(wr_size), .wr_req_sid_i(wr_sid),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
        .rsp_is_write_o(rsp_is_write), .rsp_timeout_o(rsp_timeout), .rsp_illegal_o(rsp_illegal),
        .transaction_en_o(txn_en), .addr_o(addr), .total_length_o(tlen), .num_bytes_o(nbytes),
        .sid_o(sid), .access_type_o(acc),
        .matcher_ready_i(m_ready), .matcher_valid_i(m_valid), .matcher_allow_i(m_allow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rd_valid = 0; wr_valid = 0; rsp_ready = 0;
        rd_addr = '0; rd_len = '0; rd_size = '0; rd_sid = '0;
        wr_addr = '0; wr_len = '0; wr_size = '0; wr_sid = '0;
        m_ready = 0; m_valid = 0; m_allow = 0;
        tick(); tick();
        rst = 1'b0;
        settle();
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rd_ready", 64'(rd_ready), 0);
        chk("rst_wr_ready", 64'(wr_ready), 0);
        chk("rst_txn_en", 64'(txn_en), 0);
        chk("rst_addr", addr, 0);
        chk("rst_tlen", tlen, 0);
        chk("rst_nbytes", 64'(nbytes), 0);
        chk("rst_sid", 64'(sid), 0);
        chk("rst_access", 64'(acc), 64'(ACCESS_NONE));
        chk("rst_allow", 64'(rsp_allow), 0);

        // basic read, verdict two cycles after the strobe
        rd_valid = 1; rd_addr = 64'h1000; rd_len = 3; rd_size = 3; rd_sid = 1; m_ready = 1;
        settle();
        chk("t1_rd_ready", 64'(rd_ready), 1);
        chk("t1_wr_ready", 64'(wr_ready), 0);
        tick(); rd_valid = 0; settle();
        chk("t1_txn_en", 64'(txn_en), 1);
        chk("t1_tlen", tlen, 32);
        chk("t1_nbytes", 64'(nbytes), 8);
        chk("t1_access", 64'(acc), 64'(ACCESS_READ));
        chk("t1_addr", addr, 64'h1000);
        chk("t1_sid", 64'(sid), 1);
        tick(); settle();
        chk("t1_txn_en_once", 64'(txn_en), 0);
        chk("t1_no_rsp_early", 64'(rsp_valid), 0);
        tick(); m_valid = 1; m_allow = 1; settle();
        chk("t1_no_rsp_wait", 64'(rsp_valid), 0);
        tick(); m_valid = 0; m_allow = 0; settle();
        chk("t1_rsp_valid", 64'(rsp_valid), 1);
        chk("t1_rsp_allow", 64'(rsp_allow), 1);
        chk("t1_rsp_is_write", 64'(rsp_is_write), 0);
        chk("t1_rsp_timeout", 64'(rsp_timeout), 0);
        chk("t1_rsp_illegal", 64'(rsp_illegal), 0);
        rsp_ready = 1; tick(); rsp_ready = 0; settle();
        chk("t1_rsp_done", 64'(rsp_valid), 0);

        // round-robin: both channels held valid for three accepts
        rst = 1; tick(); rst = 0;
        rd_addr = 64'h100; rd_len = 0; rd_size = 3; rd_sid = 3;
        wr_addr = 64'h200; wr_len = 3; wr_size = 2; wr_sid = 4;
        rd_valid = 1; wr_valid = 1; m_ready = 1;
        for (int k = 0; k < 3; k++) begin
            logic exp_wr;
            exp_wr = (k == 1);
            settle();
            chk("rr_rd_ready", 64'(rd_ready), 64'(!exp_wr));
            chk("rr_wr_ready", 64'(wr_ready), 64'(exp_wr));
            tick(); settle();
            chk("rr_rd_ready_pulse", 64'(rd_ready), 0);
            chk("rr_wr_ready_pulse", 64'(wr_ready), 0);
            chk("rr_access", 64'(acc), exp_wr ? 64'(ACCESS_WRITE) : 64'(ACCESS_READ));
            chk("rr_tlen", tlen, exp_wr ? 64'd16 : 64'd8);
            tick(); m_valid = 1; m_allow = 1;
            tick(); m_valid = 0; m_allow = 0; settle();
            chk("rr_rsp_valid", 64'(rsp_valid), 1);
            chk("rr_rsp_is_write", 64'(rsp_is_write), 64'(exp_wr));
            rsp_ready = 1; tick(); rsp_ready = 0;
            if (k == 2) begin rd_valid = 0; wr_valid = 0; end
        end

        // illegal size on a write
        wr_valid = 1; wr_addr = 64'h2000; wr_len = 0; wr_size = 4; wr_sid = 5;
        settle();
        chk("ill_wr_ready", 64'(wr_ready), 1);
        tick(); wr_valid = 0; settle();
        chk("ill_txn_en", 64'(txn_en), 0);
        chk("ill_rsp_valid", 64'(rsp_valid), 1);
        chk("ill_rsp_allow", 64'(rsp_allow), 0);
        chk("ill_rsp_illegal", 64'(rsp_illegal), 1);
        chk("ill_rsp_timeout", 64'(rsp_timeout), 0);
        chk("ill_rsp_is_write", 64'(rsp_is_write), 1);
        rsp_ready = 1; tick(); rsp_ready = 0;

        // watchdog timeout, then a late allow that must be discarded
        rd_valid = 1; rd_addr = 64'h3000; rd_len = 0; rd_size = 2; rd_sid = 2; m_ready = 1;
        settle();
        chk("to_rd_ready", 64'(rd_ready), 1);
        tick(); rd_valid = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("to_wait_no_rsp", 64'(rsp_valid), 0);
            tick();
        end
        settle();
        chk("to_rsp_valid", 64'(rsp_valid), 1);
        chk("to_rsp_allow", 64'(rsp_allow), 0);
        chk("to_rsp_timeout", 64'(rsp_timeout), 1);
        chk("to_rsp_illegal", 64'(rsp_illegal), 0);
        rd_valid = 1; rd_addr = 64'h4000; rd_len = 1; rd_size = 3; rd_sid = 6; rsp_ready = 1;
        settle();
        chk("to_no_accept_hs", 64'(rd_ready), 0);
        tick(); rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("to_late_block", 64'(rd_ready), 0);
            chk("to_late_no_rsp", 64'(rsp_valid), 0);
            tick();
        end
        m_valid = 1; m_allow = 1; settle();
        chk("to_late_cycle_block", 64'(rd_ready), 0);
        tick(); m_valid = 0; m_allow = 0; settle();
        chk("to_late_drop_rsp", 64'(rsp_valid), 0);
        chk("to_accept_after", 64'(rd_ready), 1);
        tick(); rd_valid = 0; settle();
        chk("to_next_addr", addr, 64'h4000);
        chk("to_next_tlen", tlen, 16);
        tick(); m_valid = 1; m_allow = 0;
        tick(); m_valid = 0; settle();
        chk("to_next_rsp_valid", 64'(rsp_valid), 1);
        chk("to_next_rsp_allow", 64'(rsp_allow), 0);
        chk("to_next_rsp_timeout", 64'(rsp_timeout), 0);
        rsp_ready = 1; tick(); rsp_ready = 0;

        // matcher back-pressure in ISSUE
        m_ready = 0;
        wr_valid = 1; wr_addr = 64'h5000; wr_len = 7; wr_size = 1; wr_sid = 9;
        settle();
        chk("bp_wr_ready", 64'(wr_ready), 1);
        tick(); wr_valid = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("bp_txn_en_low", 64'(txn_en), 0);
            chk("bp_addr_stable", addr, 64'h5000);
            chk("bp_tlen_stable", tlen, 16);
            chk("bp_no_rsp", 64'(rsp_valid), 0);
            tick();
        end
        m_ready = 1; settle();
        chk("bp_txn_en", 64'(txn_en), 1);
        tick(); m_valid = 1; m_allow = 1; settle();
        chk("bp_txn_en_once", 64'(txn_en), 0);
        tick(); m_valid = 0; m_allow = 0;

        // response stall with both channels requesting
        rd_valid = 1; rd_addr = 64'h6000; rd_len = 0; rd_size = 0; rd_sid = 7;
        wr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("st_rsp_valid", 64'(rsp_valid), 1);
            chk("st_rsp_allow", 64'(rsp_allow), 1);
            chk("st_rsp_is_write", 64'(rsp_is_write), 1);
            chk("st_rd_ready", 64'(rd_ready), 0);
            chk("st_wr_ready", 64'(wr_ready), 0);
            tick();
        end
        rsp_ready = 1; tick(); rsp_ready = 0; settle();
        chk("st_rr_rd_ready", 64'(rd_ready), 1);
        chk("st_rr_wr_ready", 64'(wr_ready), 0);

        // reset while waiting on the matcher
        tick(); rd_valid = 0; wr_valid = 0;
        tick(); rst = 1; m_valid = 1; m_allow = 1;
        tick(); rst = 0; m_valid = 0; m_allow = 0; settle();
        chk("mr_rsp_valid", 64'(rsp_valid), 0);
        chk("mr_txn_en", 64'(txn_en), 0);
        chk("mr_addr", addr, 0);
        chk("mr_tlen", tlen, 0);
        chk("mr_nbytes", 64'(nbytes), 0);
        chk("mr_sid", 64'(sid), 0);
        chk("mr_access", 64'(acc), 64'(ACCESS_NONE));
        chk("mr_allow", 64'(rsp_allow), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("mr_no_rsp", 64'(rsp_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
